// File: rtl/nibble_serial_adder_311_pkg.sv
// Shared definitions for the nibble-serial adder: slice width and controller states.
package nibble_serial_adder_311_pkg;

    localparam int unsigned NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_311_nibble_add.sv
// 4-bit ripple-carry adder built from full-adder cells, shared by every
// nibble of a serial operation.
module fa_311 (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module nibble_add_311
    import nibble_serial_adder_311_pkg::*;
(
    input  logic [NIBBLE-1:0] a,
    input  logic [NIBBLE-1:0] b,
    input  logic              cin,
    output logic [NIBBLE-1:0] s,
    output logic              cout
);
    logic [NIBBLE:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < NIBBLE; i++) begin : g_fa
        fa_311 u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_c[i]),
            .s    (s[i]),
            .cout (w_c[i+1])
        );
    end

    assign cout = w_c[NIBBLE];
endmodule

// File: rtl/nibble_serial_adder_311.sv
// Multi-nibble adder/subtractor: one 4-bit slice per cycle through a shared
// ripple adder, carry held in a register, valid/ready on both sides.
module nibble_serial_adder_311
    import nibble_serial_adder_311_pkg::*;
#(
    parameter int unsigned NIBBLES = 4,
    parameter int unsigned W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] s_311,
    output logic         cout_311,
    output logic         ovf,
    output logic         busy
);
    localparam int unsigned CW = $clog2(NIBBLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic            r_carry;
    logic            r_a_sign;
    logic            r_b_sign;
    logic [W-1:0]    r_shift;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_ovf;

    logic [NIBBLE-1:0] w_nib;
    logic              w_nib_c;
    logic [W-1:0]      w_shift_next;

    nibble_add_311 u_nibble_add (
        .a    (r_a[NIBBLE-1:0]),
        .b    (r_b[NIBBLE-1:0]),
        .cin  (r_carry),
        .s    (w_nib),
        .cout (w_nib_c)
    );

    // New nibble enters at the top; after NIBBLES shifts the LSB nibble sits at [3:0].
    assign w_shift_next = W'({w_nib, r_shift} >> NIBBLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_carry  <= 1'b0;
            r_a_sign <= 1'b0;
            r_b_sign <= 1'b0;
            r_shift  <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= sub ? ~b : b;
                        r_carry  <= sub ? 1'b1 : cin;
                        r_a_sign <= a[W-1];
                        r_b_sign <= sub ? ~b[W-1] : b[W-1];
                        r_cnt    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_shift <= w_shift_next;
                    r_a     <= r_a >> NIBBLE;
                    r_b     <= r_b >> NIBBLE;
                    r_carry <= w_nib_c;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_shift_next;
                        r_cout  <= w_nib_c;
                        r_ovf   <= (r_a_sign == r_b_sign) && (w_nib[NIBBLE-1] != r_a_sign);
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign s_311     = r_sum;
    assign cout_311  = r_cout;
    assign ovf       = r_ovf;
endmodule
